// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each grant runs a fixed IDLE -> ACCESS -> DONE sequence: strobe in ACCESS,
// one-cycle ack to the winner in DONE. All outputs come straight from flops.
module data_mem_arbiter #(
  parameter int Width     = 32,
  parameter int AddrWidth = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [AddrWidth-1:0] m0_addr,
  input  logic [Width-1:0]     m0_wdata,
  output logic                 m0_ack,
  output logic [Width-1:0]     m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [AddrWidth-1:0] m1_addr,
  input  logic [Width-1:0]     m1_wdata,
  output logic                 m1_ack,
  output logic [Width-1:0]     m1_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [Width-1:0]     mem_wdata,
  input  logic [Width-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 last_grant,
  output logic [1:0]           state_dbg
);

  // Handshake: a requester holds req (with stable we/addr/wdata) until it
  // sees its ack high for one cycle, and drops req in that same cycle. The
  // request is captured on the grant edge, so later input changes, including
  // dropping req early, do not disturb the transaction already in flight.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [Width-1:0]       wdata_q, wdata_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic                   m0_ack_q, m0_ack_d;
  logic                   m1_ack_q, m1_ack_d;
  logic [Width-1:0]       m0_rdata_q, m0_rdata_d;
  logic [Width-1:0]       m1_rdata_q, m1_rdata_d;
  logic                   winner;
  logic                   win_we;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    winner = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    win_we = winner ? m1_we : m0_we;
  end

  // Next-state and next-output computation; strobes and acks default low.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = ACCESS;
          last_grant_d = winner;
          we_d         = win_we;
          addr_d       = winner ? m1_addr : m0_addr;
          wdata_d      = winner ? m1_wdata : m0_wdata;
          mem_read_d   = ~win_we;
          mem_write_d  = win_we;
        end
      end
      ACCESS: begin
        state_d = DONE;
        // Read data is captured on the edge leaving ACCESS, into the winner only.
        if (!we_q) begin
          if (last_grant_q) m1_rdata_d = mem_rdata;
          else              m0_rdata_d = mem_rdata;
        end
        m0_ack_d = ~last_grant_q;
        m1_ack_d = last_grant_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state/output register bank; reset is asynchronous and parks the
  // grant pointer on requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 512-word memory.
module tb_data_mem_arbiter;

  localparam int W  = 32;
  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          busy, last_grant;
  logic [1:0]    state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory model: word i holds i after every reset; writes land on the clock edge.
  logic [W-1:0] mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= W'(i);
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  data_mem_arbiter #(.Width(W), .AddrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .last_grant(last_grant), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step(); step();
    tests_run++; if (mem_read !== 1'b0)   begin tests_failed++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
    tests_run++; if (mem_write !== 1'b0)  begin tests_failed++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
    tests_run++; if (mem_addr !== '0)     begin tests_failed++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    tests_run++; if (mem_wdata !== '0)    begin tests_failed++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    tests_run++; if ({m0_ack, m1_ack} !== 2'b00) begin tests_failed++; $display("FAIL rst_acks got=%b exp=00", {m0_ack, m1_ack}); end
    tests_run++; if (m0_rdata !== '0)     begin tests_failed++; $display("FAIL rst_m0_rdata got=%h exp=0", m0_rdata); end
    tests_run++; if (m1_rdata !== '0)     begin tests_failed++; $display("FAIL rst_m1_rdata got=%h exp=0", m1_rdata); end
    tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL rst_last_grant got=%b exp=1", last_grant); end
    tests_run++; if (state_dbg !== 2'd0)  begin tests_failed++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    rst_n = 1;
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_no_req got=%b exp=0", busy); end
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 9'd5;
    step();  // grant edge
    tests_run++; if ({mem_read, mem_write} !== 2'b10) begin tests_failed++; $display("FAIL rd_strobes got=%b exp=10", {mem_read, mem_write}); end
    tests_run++; if (mem_addr !== 9'd5) begin tests_failed++; $display("FAIL rd_addr got=%0d exp=5", mem_addr); end
    tests_run++; if (busy !== 1'b1 || last_grant !== 1'b0) begin tests_failed++; $display("FAIL rd_grant busy=%b lg=%b exp busy=1 lg=0", busy, last_grant); end
    tests_run++; if ({m0_ack, m1_ack} !== 2'b00) begin tests_failed++; $display("FAIL rd_early_ack got=%b exp=00", {m0_ack, m1_ack}); end
    step();
    tests_run++; if ({m0_ack, m1_ack} !== 2'b10) begin tests_failed++; $display("FAIL rd_ack got=%b exp=10", {m0_ack, m1_ack}); end
    tests_run++; if ({mem_read, mem_write} !== 2'b00) begin tests_failed++; $display("FAIL rd_done_strobes got=%b exp=00", {mem_read, mem_write}); end
    tests_run++; if (m0_rdata !== 32'h0000_0005) begin tests_failed++; $display("FAIL rd_data got=%h exp=00000005", m0_rdata); end
    tests_run++; if (m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL rd_other_hold got=%h exp=0", m1_rdata); end
    m0_req = 0;
    step();
    tests_run++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rd_after ack=%b busy=%b exp 0 0", m0_ack, busy); end
  endtask

  task automatic test_write_read();
    m1_req = 1; m1_we = 1; m1_addr = 9'd10; m1_wdata = 32'hDEAD_BEEF;
    step();
    tests_run++; if ({mem_read, mem_write} !== 2'b01) begin tests_failed++; $display("FAIL wr_strobes got=%b exp=01", {mem_read, mem_write}); end
    tests_run++; if (mem_addr !== 9'd10 || mem_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_bus addr=%0d data=%h exp 10 deadbeef", mem_addr, mem_wdata); end
    step();
    tests_run++; if ({m0_ack, m1_ack, mem_write} !== 3'b010) begin tests_failed++; $display("FAIL wr_ack m0_ack/m1_ack/mem_write got=%b exp=010", {m0_ack, m1_ack, mem_write}); end
    tests_run++; if (m0_rdata !== 32'h5 || m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rdata_hold m0=%h m1=%h exp 5 0", m0_rdata, m1_rdata); end
    m1_req = 0;
    step();
    m1_req = 1; m1_we = 0; m1_wdata = '0;
    step();
    tests_run++; if ({mem_read, mem_write} !== 2'b10) begin tests_failed++; $display("FAIL wr_rd_strobes got=%b exp=10", {mem_read, mem_write}); end
    step();
    tests_run++; if (m1_ack !== 1'b1) begin tests_failed++; $display("FAIL wr_rd_ack got=%b exp=1", m1_ack); end
    tests_run++; if (m1_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_rd_data got=%h exp=deadbeef", m1_rdata); end
    tests_run++; if (m0_rdata !== 32'h5) begin tests_failed++; $display("FAIL wr_rd_m0_hold got=%h exp=5", m0_rdata); end
    m1_req = 0;
    step();
  endtask

  task automatic test_contention();
    logic exp_q[$];
    int   ack_cnt;
    idle_inputs();
    do_reset();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    ack_cnt = 0;
    m0_req = 1; m0_addr = 9'd1;
    m1_req = 1; m1_addr = 9'd2;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (m0_ack || m1_ack) begin
        tests_run++;
        if (exp_q.size() == 0 || cyc != 2 + 3*ack_cnt ||
            {m0_ack, m1_ack} !== (exp_q[0] ? 2'b01 : 2'b10)) begin
          tests_failed++;
          $display("FAIL cont_ack cycle=%0d acks=%b exp_cycle=%0d", cyc, {m0_ack, m1_ack}, 2 + 3*ack_cnt);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        ack_cnt++;
      end
    end
    tests_run++; if (ack_cnt != 4) begin tests_failed++; $display("FAIL cont_ack_count got=%0d exp=4", ack_cnt); end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_withdrawn();
    int acks;
    acks = 0;
    m0_req = 1; m0_we = 0; m0_addr = 9'd7;
    step();
    m0_req = 0; m0_addr = 9'd9;  // drop req and change addr after grant
    tests_run++; if (mem_read !== 1'b1 || last_grant !== 1'b0) begin tests_failed++; $display("FAIL wd_grant rd=%b lg=%b exp 1 0", mem_read, last_grant); end
    #2;
    tests_run++; if (mem_addr !== 9'd7) begin tests_failed++; $display("FAIL wd_addr_stable got=%0d exp=7", mem_addr); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (m0_ack) acks++;
      if (i == 0) begin
        tests_run++; if (m0_rdata !== 32'd7) begin tests_failed++; $display("FAIL wd_data got=%h exp=7", m0_rdata); end
      end
    end
    tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL wd_ack_count got=%0d exp=1", acks); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wd_regrant busy=%b exp=0", busy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    int acks;
    acks = 0;
    m0_req = 1; m0_we = 0; m0_addr = 9'd3;
    step();
    tests_run++; if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL rma_pre_strobe got=%b exp=1", mem_read); end
    #2 rst_n = 0;
    #1;
    tests_run++; if ({mem_read, mem_write} !== 2'b00) begin tests_failed++; $display("FAIL rma_strobes got=%b exp=00", {mem_read, mem_write}); end
    tests_run++; if (busy !== 1'b0 || last_grant !== 1'b1) begin tests_failed++; $display("FAIL rma_state busy=%b lg=%b exp 0 1", busy, last_grant); end
    tests_run++; if ({m0_ack, m1_ack} !== 2'b00 || m0_rdata !== '0) begin tests_failed++; $display("FAIL rma_outputs acks=%b m0_rdata=%h exp 00 0", {m0_ack, m1_ack}, m0_rdata); end
    idle_inputs();
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m0_ack || m1_ack) acks++;
    end
    tests_run++; if (acks != 0) begin tests_failed++; $display("FAIL rma_no_ack got=%0d exp=0", acks); end
    m0_req = 1; m0_addr = 9'd4; m1_req = 1; m1_addr = 9'd6;
    step();
    tests_run++; if (last_grant !== 1'b0 || mem_addr !== 9'd4) begin tests_failed++; $display("FAIL rma_first_tie lg=%b addr=%0d exp 0 4", last_grant, mem_addr); end
    step();
    tests_run++; if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'd4) begin tests_failed++; $display("FAIL rma_first_ack acks=%b data=%h exp 10 4", {m0_ack, m1_ack}, m0_rdata); end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_random_strobes();
    int bad;
    for (int i = 0; i < 10000; i++) begin
      m0_req   = 1'($urandom_range(0, 1));
      m0_we    = 1'($urandom_range(0, 1));
      m0_addr  = AW'($urandom_range(0, 511));
      m0_wdata = $urandom;
      m1_req   = 1'($urandom_range(0, 1));
      m1_we    = 1'($urandom_range(0, 1));
      m1_addr  = AW'($urandom_range(0, 511));
      m1_wdata = $urandom;
      step();
      bad = 0;
      if (mem_read && mem_write) bad = 1;
      if ((mem_read || mem_write) && !busy) bad = 1;
      if (m0_ack && m1_ack) bad = 1;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL rand_strobes cycle=%0d rd=%b wr=%b busy=%b acks=%b", i, mem_read, mem_write, busy, {m0_ack, m1_ack});
      end
    end
    idle_inputs();
    step(); step(); step();
  endtask

  // Test sequence and final report
  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_withdrawn();
    test_reset_mid_access();
    test_random_strobes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, giving the data word width.
REQ-002 SHALL have parameter AddrWidth, default 9, giving the word-address width (512-word memory).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port m0_req  input  1  requester 0 access request, level held until ack.
REQ-006 SHALL have port m0_we  input  1  requester 0 write (1) / read (0).
REQ-007 SHALL have port m0_addr  input  AddrWidth  requester 0 word address.
REQ-008 SHALL have port m0_wdata  input  Width  requester 0 write data.
REQ-009 SHALL have port m0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-010 SHALL have port m0_rdata  output  Width  requester 0 read data, registered.
REQ-011 SHALL have ports m1_req, m1_we, m1_addr, m1_wdata, m1_ack and m1_rdata, identical to REQ-005..010 for requester 1.
REQ-012 SHALL have port mem_read  output  1  memory read strobe.
REQ-013 SHALL have port mem_write  output  1  memory write strobe.
REQ-014 SHALL have port mem_addr  output  AddrWidth  memory address.
REQ-015 SHALL have port mem_wdata  output  Width  memory write data.
REQ-016 SHALL have port mem_rdata  input  Width  combinational read data from memory.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port last_grant  output  1  index of the most recently granted requester.

Function
REQ-019 SHALL implement a three-state FSM with states IDLE, ACCESS and DONE.
REQ-020 In IDLE with any req high, SHALL select a winner, latch its we/addr/wdata and index, and go to ACCESS; with no req, SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: if only one req is high it wins; if both are high, the requester not equal to last_grant wins.
REQ-022 last_grant SHALL update to the winner index on the transition into ACCESS.
REQ-023 In ACCESS, SHALL drive mem_addr and mem_wdata from the latched values and assert exactly one strobe: mem_write if latched we=1, else mem_read.
REQ-024 In ACCESS on a read, SHALL capture mem_rdata into the winner's rdata register at the clock edge leaving ACCESS; the other rdata register SHALL hold.
REQ-025 mem_read and mem_write SHALL be 0 in IDLE and DONE and SHALL never both be 1.
REQ-026 ACCESS SHALL always go to DONE after one cycle.
REQ-027 In DONE, SHALL assert the winner's ack for exactly that cycle, then go to IDLE.
REQ-028 Latency SHALL be fixed: req sampled at edge N, strobe asserted during cycle N+1, ack high during cycle N+2, with a minimum of 3 cycles between grants.
REQ-029 A req still high in the IDLE cycle after ack SHALL be treated as a new request; requesters deassert req in the cycle ack is seen.
REQ-030 Changes to req, we, addr or wdata after grant SHALL NOT affect the transaction in flight; a req dropped mid-transaction SHALL still complete and ack.
REQ-031 A write transaction SHALL leave both rdata registers unchanged.
REQ-032 A requester that loses arbitration SHALL receive no ack and SHALL be granted next if its req remains high.

Reset
REQ-033 On rst_n low, SHALL immediately, without waiting for clk, force the state to IDLE and drive these values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, m0_ack=0, m1_ack=0, m0_rdata=0, m1_rdata=0, busy=0, last_grant=1.
REQ-034 Reset asserted during ACCESS or DONE SHALL abort the transaction with no ack; after release, the first simultaneous request SHALL be granted to requester 0.

Verification
REQ-035 Single read: memory word 5 holds 0x00000005; m0 reads addr 5 -> mem_read high in cycle 2, m0_ack in cycle 3, m0_rdata=0x00000005.
REQ-036 Write then read: m1 writes 0xDEADBEEF to addr 10, then m1 reads addr 10 -> mem_write in one cycle only, then m1_rdata=0xDEADBEEF; m0_rdata unchanged.
REQ-037 Contention: m0 and m1 both request continuously from reset -> grants alternate m0,m1,m0,m1; each ack is 3 cycles after the previous one.
REQ-038 Request withdrawn: m0_req pulsed for only the grant cycle -> access still performed, m0_ack pulses once, no second grant.
REQ-039 Reset mid-ACCESS: rst_n low during cycle 2 -> strobes drop to 0 without a clock edge, no ack, busy=0, last_grant=1.
REQ-040 Strobe exclusivity: random traffic for 10k cycles -> mem_read & mem_write never both 1, and strobes only asserted while busy=1.
